// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared AXI4 types and helpers used by the read-channel subordinate.
//   AxiSize_t / AxiBurst_t / AxiResp_t : AXI encodings
//   AXI_BURST_RSVD                     : reserved burst encoding
//   axiSize2bytes(size)                : bytes per beat for an AxSIZE value
//   axiAccepted(valid, ready)          : channel handshake
//   axiWrapLenLegal(len)               : WRAP bursts need 2/4/8/16 beats
//   axiNextAddr(addr,size,len,burst)   : address of the following beat
// Addresses are handled at 64 bits here; callers cast to their own width,
// which also gives the modulo-2^ADDR_W wrap for INCR bursts.
// ---------------------------------------------------------------------------
package axi_pkg;

    typedef enum logic [2:0] {
        SIZE_1   = 3'd0,
        SIZE_2   = 3'd1,
        SIZE_4   = 3'd2,
        SIZE_8   = 3'd3,
        SIZE_16  = 3'd4,
        SIZE_32  = 3'd5,
        SIZE_64  = 3'd6,
        SIZE_128 = 3'd7
    } AxiSize_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } AxiBurst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } AxiResp_t;

    localparam logic [1:0] AXI_BURST_RSVD = 2'd3;

    function automatic logic [7:0] axiSize2bytes(input AxiSize_t size);
        return 8'd1 << size;
    endfunction

    function automatic logic axiAccepted(input logic valid, input logic ready);
        return valid & ready;
    endfunction

    function automatic logic axiWrapLenLegal(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // INCR aligns down to the beat size before stepping, so an unaligned
    // first beat is followed by aligned beats.
    function automatic logic [63:0] axiNextAddr(input logic [63:0] addr,
                                                input AxiSize_t    size,
                                                input logic [7:0]  len,
                                                input logic [1:0]  burst);
        logic [63:0] step;
        logic [63:0] wrap_mask;
        step      = 64'(axiSize2bytes(size));
        wrap_mask = ((64'(len) + 64'd1) << size) - 64'd1;
        case (burst)
            BURST_INCR: axiNextAddr = (addr & ~(step - 64'd1)) + step;
            BURST_WRAP: axiNextAddr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
            default:    axiNextAddr = addr;
        endcase
    endfunction

endpackage

// File: rtl/axi_rd_skid_buf.sv
// ---------------------------------------------------------------------------
// axi_rd_skid_buf
// Two-entry FIFO between the memory return path and the R channel.
//   clk, rst      : clock, asynchronous active-high reset
//   i_push        : write i_push_data this cycle (caller guarantees space,
//                   or a simultaneous pop when full)
//   o_valid       : head entry present
//   i_ready       : consumer accepts the head entry
//   o_data        : head entry
//   o_count       : number of stored entries (0..2)
// ---------------------------------------------------------------------------
module axi_rd_skid_buf #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_push,
    input  logic [PAYLOAD_W-1:0] i_push_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [PAYLOAD_W-1:0] o_data,
    output logic [1:0]           o_count
);

    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       w_pop;

    assign o_valid = (r_count != 2'd0);
    assign w_pop   = o_valid & i_ready;
    assign o_count = r_count;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [PAYLOAD_W-1:0] r_data;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_data <= '0;
                end else if (i_push && (r_wr_ptr == 1'(gi))) begin
                    r_data <= i_push_data;
                end
            end
        end
    endgenerate

    assign o_data = r_rd_ptr ? g_entry[1].r_data : g_entry[0].r_data;

    // When full, the write pointer equals the read pointer, so a push with a
    // pop overwrites the entry leaving this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(i_push) - 2'(w_pop);
        end
    end

endmodule

// File: rtl/axi_rd_subordinate.sv
// ---------------------------------------------------------------------------
// axi_rd_subordinate
// AXI4 read-channel responder in front of a synchronous-read memory port.
// One AR burst at a time; FIXED/INCR/WRAP address generation; errors are
// decided at AR capture and apply to every beat of the burst.
//   clk, rst                         : clock, asynchronous active-high reset
//   s_ar{valid,ready,addr,len,size,burst,id} : AR channel
//   s_r{valid,ready,data,resp,last,id}       : R channel
//   mem_req, mem_addr                : read strobe and beat-aligned address
//   mem_rdata                        : data, one cycle after mem_req
// Optional build macro AXI_RD_UNALIGNED_EN: accept unaligned FIXED/INCR
// start addresses (WRAP with an unaligned start stays SLVERR).
// ---------------------------------------------------------------------------
module axi_rd_subordinate
    import axi_pkg::*;
#(
    parameter int               DATA_W     = 32,
    parameter int               ADDR_W     = 32,
    parameter int               ID_W       = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(32'h0000_0000),
    parameter logic [ADDR_W-1:0] SPAN_BYTES = ADDR_W'(32'h0001_0000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic [7:0]        s_arlen,
    input  logic [2:0]        s_arsize,
    input  logic [1:0]        s_arburst,
    input  logic [ID_W-1:0]   s_arid,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic [ID_W-1:0]   s_rid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               PAYLOAD_W = DATA_W + 2 + 1 + ID_W;
    localparam logic [2:0]       LANE_SIZE = 3'($clog2(DATA_W / 8));
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(DATA_W / 8 - 1);

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_arready;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    AxiSize_t          r_size;
    logic [1:0]        r_burst;
    logic [ID_W-1:0]   r_id;
    AxiResp_t          r_resp;
    logic [7:0]        r_issue_idx;
    logic              r_issue_done;
    logic              r_inflight;
    logic              r_inflight_last;

    logic              w_ar_hs;
    logic              w_r_hs;
    logic [1:0]        w_buf_count;
    logic [2:0]        w_occupancy;
    logic              w_issue;
    logic              w_issue_last;
    logic              w_is_err;
    logic              w_err_push;
    logic              w_push;
    logic [PAYLOAD_W-1:0] w_push_data;
    logic [PAYLOAD_W-1:0] w_head;
    logic [ADDR_W-1:0] w_addr_next;

    logic [ADDR_W-1:0] w_ar_off;
    logic [ADDR_W-1:0] w_size_mask;
    logic              w_ar_wrap;
    logic              w_dec_err;
    logic              w_slv_err;
    logic              w_align_err;
    AxiResp_t          w_ar_resp;

    // ---------------- AR decode ----------------
    assign w_ar_off    = s_araddr - BASE_ADDR;
    assign w_dec_err   = (s_araddr < BASE_ADDR) || (w_ar_off >= SPAN_BYTES);
    assign w_size_mask = ADDR_W'(axiSize2bytes(AxiSize_t'(s_arsize))) - ADDR_W'(1);
    assign w_ar_wrap   = (s_arburst == BURST_WRAP);

`ifdef AXI_RD_UNALIGNED_EN
    assign w_align_err = ((s_araddr & w_size_mask) != '0) && w_ar_wrap;
`else
    assign w_align_err = ((s_araddr & w_size_mask) != '0);
`endif

    assign w_slv_err = (s_arsize > LANE_SIZE)
                    || (w_ar_wrap && !axiWrapLenLegal(s_arlen))
                    || (s_arburst == AXI_BURST_RSVD)
                    || w_align_err;

    // Decode error takes priority over protocol errors.
    always_comb begin
        w_ar_resp = RESP_OKAY;
        if (w_slv_err) begin
            w_ar_resp = RESP_SLVERR;
        end
        if (w_dec_err) begin
            w_ar_resp = RESP_DECERR;
        end
    end

    // ---------------- handshakes / beat issue ----------------
    assign s_arready = r_arready;
    assign w_ar_hs   = axiAccepted(s_arvalid, r_arready);
    assign w_r_hs    = axiAccepted(s_rvalid, s_rready);

    // Buffered + in-flight beats after this cycle's pop must leave room.
    assign w_occupancy  = 3'(w_buf_count) + 3'(r_inflight) - 3'(w_r_hs);
    assign w_issue      = (r_state == ST_BURST) && !r_issue_done && (w_occupancy < 3'd2);
    assign w_issue_last = (r_issue_idx == r_len);
    assign w_is_err     = (r_resp != RESP_OKAY);

    assign mem_req  = w_issue && !w_is_err;
    assign mem_addr = r_addr & ~LANE_MASK;

    // Error beats skip the memory and enter the buffer straight away.
    assign w_err_push = w_issue && w_is_err;
    assign w_push     = r_inflight | w_err_push;
    assign w_push_data = r_inflight
        ? {mem_rdata, RESP_OKAY, r_inflight_last, r_id}
        : {{DATA_W{1'b0}}, r_resp, w_issue_last, r_id};

    assign w_addr_next = ADDR_W'(axiNextAddr(64'(r_addr), r_size, r_len, r_burst));

    // ---------------- FSM ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_ar_hs) w_state_next = ST_BURST;
            ST_BURST: if (w_r_hs && s_rlast) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_arready       <= 1'b0;
            r_addr          <= '0;
            r_len           <= 8'd0;
            r_size          <= SIZE_1;
            r_burst         <= 2'd0;
            r_id            <= '0;
            r_resp          <= RESP_OKAY;
            r_issue_idx     <= 8'd0;
            r_issue_done    <= 1'b1;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_arready       <= (w_state_next == ST_IDLE);
            r_inflight      <= mem_req;
            r_inflight_last <= w_issue_last;
            if (w_ar_hs) begin
                r_addr       <= s_araddr;
                r_len        <= s_arlen;
                r_size       <= AxiSize_t'(s_arsize);
                r_burst      <= s_arburst;
                r_id         <= s_arid;
                r_resp       <= w_ar_resp;
                r_issue_idx  <= 8'd0;
                r_issue_done <= 1'b0;
            end else if (w_issue) begin
                r_addr <= w_addr_next;
                if (w_issue_last) begin
                    r_issue_done <= 1'b1;
                end else begin
                    r_issue_idx <= r_issue_idx + 8'd1;
                end
            end
        end
    end

    // ---------------- output buffer ----------------
    axi_rd_skid_buf #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .o_valid     (s_rvalid),
        .i_ready     (s_rready),
        .o_data      (w_head),
        .o_count     (w_buf_count)
    );

    assign {s_rdata, s_rresp, s_rlast, s_rid} = w_head;

endmodule

// File: tb/tb_axi_rd_subordinate.sv
module tb_axi_rd_subordinate;
    import axi_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_arvalid;
    logic              s_arready;
    logic [ADDR_W-1:0] s_araddr;
    logic [7:0]        s_arlen;
    logic [2:0]        s_arsize;
    logic [1:0]        s_arburst;
    logic [ID_W-1:0]   s_arid;
    logic              s_rvalid;
    logic              s_rready;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rlast;
    logic [ID_W-1:0]   s_rid;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    axi_rd_subordinate #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .ID_W       (ID_W),
        .BASE_ADDR  (32'h0000_0000),
        .SPAN_BYTES (32'h0001_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_araddr  (s_araddr),
        .s_arlen   (s_arlen),
        .s_arsize  (s_arsize),
        .s_arburst (s_arburst),
        .s_arid    (s_arid),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .s_rid     (s_rid),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    // Memory model: word at address A reads as {16'hC0DE, A[15:0]}.
    always @(posedge clk) begin
        mem_rdata <= mem_req ? {16'hC0DE, mem_addr[15:0]} : 32'hDEAD_BEEF;
    end

    // ---------------- monitor (samples on the falling edge) ----------------
    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
        int          cyc;
    } beat_t;

    int          cyc = 0;
    beat_t       beats[$];
    logic [31:0] reqs[$];
    int          req_cycs[$];
    int          ar_cycs[$];
    int          n_req = 0;
    int          n_ok = 0;
    int          max_outst = 0;
    int          stable_viol = 0;
    logic        stall_prev = 1'b0;
    logic [38:0] stall_snap = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            stall_prev <= 1'b0;
        end else begin
            if (s_arvalid && s_arready) ar_cycs.push_back(cyc);
            if (mem_req) begin
                reqs.push_back(mem_addr);
                req_cycs.push_back(cyc);
                n_req <= n_req + 1;
            end
            if (s_rvalid && s_rready) begin
                beats.push_back('{s_rdata, s_rresp, s_rlast, s_rid, cyc});
                if (s_rresp == 2'd0) n_ok <= n_ok + 1;
            end
            max_outst <= ((n_req - n_ok) > max_outst) ? (n_req - n_ok) : max_outst;
            if (stall_prev && (!s_rvalid || ({s_rdata, s_rresp, s_rlast, s_rid} !== stall_snap)))
                stable_viol <= stable_viol + 1;
            stall_prev <= s_rvalid && !s_rready;
            stall_snap <= {s_rdata, s_rresp, s_rlast, s_rid};
        end
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [3:0] id);
        bit ok;
        ok        = 1'b0;
        s_araddr  = a;
        s_arlen   = len;
        s_arsize  = size;
        s_arburst = burst;
        s_arid    = id;
        s_arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_arready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("ar_handshake_timeout", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        s_arvalid = 1'b0;
    endtask

    task automatic wait_beats(input int target, input bit toggle);
        int guard;
        guard = 0;
        while (beats.size() < target && guard < 300) begin
            @(posedge clk);
            #1;
            s_rready = toggle ? ~s_rready : 1'b1;
            guard++;
        end
        if (beats.size() < target) chk("beat_timeout", 64'(beats.size()), 64'(target));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    int b0, r0, a0;
    logic [31:0] exp_wrap[4];

    initial begin
        s_arvalid = 1'b0;
        s_araddr  = '0;
        s_arlen   = '0;
        s_arsize  = '0;
        s_arburst = '0;
        s_arid    = '0;
        s_rready  = 1'b1;
        rst       = 1'b1;
        exp_wrap  = '{32'hC0DE_000C, 32'hC0DE_0000, 32'hC0DE_0004, 32'hC0DE_0008};
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_arready", 64'(s_arready), 64'd0);
        chk("rst_rvalid",  64'(s_rvalid),  64'd0);
        chk("rst_rlast",   64'(s_rlast),   64'd0);
        chk("rst_rresp",   64'(s_rresp),   64'd0);
        chk("rst_rdata",   64'(s_rdata),   64'd0);
        chk("rst_rid",     64'(s_rid),     64'd0);
        chk("rst_mem_req", 64'(mem_req),   64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("arready_after_rst", 64'(s_arready), 64'd1);

        // 1: INCR 0x100 len 3 size 4, full rready
        b0 = beats.size(); r0 = reqs.size(); a0 = ar_cycs.size();
        send_ar(32'h100, 8'd3, 3'd2, 2'd1, 4'd5);
        chk("t1_arready_busy", 64'(s_arready), 64'd0);
        wait_beats(b0 + 4, 1'b0);
        chk("t1_arready_rise", 64'(s_arready), 64'd1);
        chk("t1_nreq", 64'(reqs.size() - r0), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_mem_addr%0d", i), 64'(reqs[r0+i]), 64'(32'h100 + 4*i));
            chk($sformatf("t1_data%0d", i), 64'(beats[b0+i].data), 64'(32'hC0DE_0100 + 4*i));
            chk($sformatf("t1_last%0d", i), 64'(beats[b0+i].last), 64'(i == 3));
            chk($sformatf("t1_resp%0d", i), 64'(beats[b0+i].resp), 64'd0);
            chk($sformatf("t1_id%0d", i), 64'(beats[b0+i].id), 64'd5);
        end
        chk("t1_req_latency", 64'(req_cycs[r0] - ar_cycs[a0]), 64'd1);
        chk("t1_req_b2b", 64'(req_cycs[r0+3] - req_cycs[r0]), 64'd3);
        chk("t1_rvalid_latency", 64'(beats[b0].cyc - ar_cycs[a0]), 64'd3);
        chk("t1_beats_b2b", 64'(beats[b0+3].cyc - beats[b0].cyc), 64'd3);

        // 2: WRAP 0x0C len 3 size 4
        b0 = beats.size(); r0 = reqs.size();
        send_ar(32'h0C, 8'd3, 3'd2, 2'd2, 4'd6);
        wait_beats(b0 + 4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_mem_addr%0d", i), 64'(reqs[r0+i]), 64'(exp_wrap[i] & 32'hFFFF));
            chk($sformatf("t2_data%0d", i), 64'(beats[b0+i].data), 64'(exp_wrap[i]));
            chk($sformatf("t2_last%0d", i), 64'(beats[b0+i].last), 64'(i == 3));
        end

        // 3: INCR 0x200 len 7, rready toggling every cycle
        b0 = beats.size(); r0 = reqs.size();
        send_ar(32'h200, 8'd7, 3'd2, 2'd1, 4'hA);
        wait_beats(b0 + 8, 1'b1);
        s_rready = 1'b1;
        idle(6);
        chk("t3_beat_count", 64'(beats.size() - b0), 64'd8);
        chk("t3_rvalid_drained", 64'(s_rvalid), 64'd0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_data%0d", i), 64'(beats[b0+i].data), 64'(32'hC0DE_0200 + 4*i));
            chk($sformatf("t3_last%0d", i), 64'(beats[b0+i].last), 64'(i == 7));
            chk($sformatf("t3_id%0d", i), 64'(beats[b0+i].id), 64'hA);
        end
        chk("t3_r_stable", 64'(stable_viol), 64'd0);
        chk("t3_outstanding_le2", 64'(max_outst <= 2), 64'd1);

        // 4: start just past the window -> DECERR, no memory reads
        b0 = beats.size(); r0 = reqs.size(); a0 = ar_cycs.size();
        send_ar(32'h0001_0000, 8'd2, 3'd2, 2'd1, 4'd3);
        wait_beats(b0 + 3, 1'b0);
        chk("t4_no_mem_req", 64'(reqs.size() - r0), 64'd0);
        chk("t4_rvalid_latency", 64'(beats[b0].cyc - ar_cycs[a0]), 64'd2);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t4_resp%0d", i), 64'(beats[b0+i].resp), 64'd3);
            chk($sformatf("t4_data%0d", i), 64'(beats[b0+i].data), 64'd0);
            chk($sformatf("t4_last%0d", i), 64'(beats[b0+i].last), 64'(i == 2));
            chk($sformatf("t4_id%0d", i), 64'(beats[b0+i].id), 64'd3);
        end

        // 5: unaligned INCR start 0x102, size 4, len 1
        b0 = beats.size(); r0 = reqs.size();
        send_ar(32'h102, 8'd1, 3'd2, 2'd1, 4'd7);
        wait_beats(b0 + 2, 1'b0);
`ifdef AXI_RD_UNALIGNED_EN
        chk("t5_nreq", 64'(reqs.size() - r0), 64'd2);
        chk("t5_mem_addr0", 64'(reqs[r0]), 64'h100);
        chk("t5_mem_addr1", 64'(reqs[r0+1]), 64'h104);
        chk("t5_resp0", 64'(beats[b0].resp), 64'd0);
        chk("t5_data0", 64'(beats[b0].data), 64'hC0DE_0100);
        chk("t5_data1", 64'(beats[b0+1].data), 64'hC0DE_0104);
`else
        chk("t5_nreq", 64'(reqs.size() - r0), 64'd0);
        chk("t5_resp0", 64'(beats[b0].resp), 64'd2);
        chk("t5_resp1", 64'(beats[b0+1].resp), 64'd2);
        chk("t5_data0", 64'(beats[b0].data), 64'd0);
`endif
        chk("t5_last0", 64'(beats[b0].last), 64'd0);
        chk("t5_last1", 64'(beats[b0+1].last), 64'd1);

        // 5b: size wider than the bus -> SLVERR
        b0 = beats.size(); r0 = reqs.size();
        send_ar(32'h0, 8'd0, 3'd3, 2'd1, 4'd1);
        wait_beats(b0 + 1, 1'b0);
        chk("t5b_resp", 64'(beats[b0].resp), 64'd2);
        chk("t5b_last", 64'(beats[b0].last), 64'd1);
        chk("t5b_no_mem_req", 64'(reqs.size() - r0), 64'd0);

        // 5c: WRAP with 3 beats -> SLVERR on all 3
        b0 = beats.size(); r0 = reqs.size();
        send_ar(32'h0, 8'd2, 3'd2, 2'd2, 4'd4);
        wait_beats(b0 + 3, 1'b0);
        chk("t5c_resp0", 64'(beats[b0].resp), 64'd2);
        chk("t5c_resp2", 64'(beats[b0+2].resp), 64'd2);
        chk("t5c_last2", 64'(beats[b0+2].last), 64'd1);
        chk("t5c_no_mem_req", 64'(reqs.size() - r0), 64'd0);

        // 5d: reserved burst encoding -> SLVERR
        b0 = beats.size();
        send_ar(32'h0, 8'd0, 3'd2, 2'd3, 4'd8);
        wait_beats(b0 + 1, 1'b0);
        chk("t5d_resp", 64'(beats[b0].resp), 64'd2);
        chk("t5d_id", 64'(beats[b0].id), 64'd8);

        // 6: reset after the first beat of a len-3 burst
        b0 = beats.size();
        send_ar(32'h300, 8'd3, 3'd2, 2'd1, 4'd9);
        wait_beats(b0 + 1, 1'b0);
        rst = 1'b1;
        #1;
        chk("t6_rvalid_in_rst", 64'(s_rvalid), 64'd0);
        chk("t6_mem_req_in_rst", 64'(mem_req), 64'd0);
        chk("t6_arready_in_rst", 64'(s_arready), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        b0 = beats.size(); r0 = reqs.size();
        @(posedge clk);
        #1;
        chk("t6_arready_after_rst", 64'(s_arready), 64'd1);
        send_ar(32'h40, 8'd0, 3'd2, 2'd0, 4'd2);
        wait_beats(b0 + 1, 1'b0);
        idle(6);
        chk("t6_beat_count", 64'(beats.size() - b0), 64'd1);
        chk("t6_data", 64'(beats[b0].data), 64'hC0DE_0040);
        chk("t6_last", 64'(beats[b0].last), 64'd1);
        chk("t6_resp", 64'(beats[b0].resp), 64'd0);
        chk("t6_id", 64'(beats[b0].id), 64'd2);
        chk("t6_nreq", 64'(reqs.size() - r0), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_rd_subordinate.md
Name: axi_rd_subordinate

Overview:
AXI4 read-channel subordinate (responder) sitting between an AXI read initiator and a simple synchronous-read memory port. Accepts one AR transaction at a time and generates all address beats (FIXED/INCR/WRAP) toward memory. Returns R beats with correct RID/RRESP/RLAST. Sustains 1 beat/cycle under full RREADY through a 2-entry output buffer.

Parameters:
DATA_W, 32, R data width in bits (power of 2, 8..128)
ADDR_W, 32, address width
ID_W, 4, ARID/RID width
BASE_ADDR, 32'h0000_0000, first decoded byte address
SPAN_BYTES, 32'h0001_0000, decoded window size in bytes (power of 2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
s_arvalid  in  1  AR valid
s_arready  out  1  AR ready
s_araddr  in  ADDR_W  start byte address
s_arlen  in  8  beats minus 1
s_arsize  in  3  AxiSize_t
s_arburst  in  2  AxiBurst_t
s_arid  in  ID_W  transaction ID
s_rvalid  out  1  R valid
s_rready  in  1  R ready
s_rdata  out  DATA_W  read data
s_rresp  out  2  AxiResp_t
s_rlast  out  1  last beat
s_rid  out  ID_W  echoes ARID
mem_req  out  1  memory read strobe
mem_addr  out  ADDR_W  byte address, aligned to DATA_W/8
mem_rdata  in  DATA_W  valid exactly 1 cycle after mem_req

Behaviour:
- Reset (async, rst=1): state IDLE; s_arready=0, s_rvalid=0, s_rlast=0, s_rresp=OKAY, s_rdata=0, s_rid=0, mem_req=0; buffer empty, in-flight=0. s_arready goes 1 on the first clk edge after rst deasserts.
- Reset mid-burst: burst is abandoned and no further R beats are produced. The returning mem_rdata is ignored.
- FSM: IDLE -> (arvalid&arready) -> BURST. BURST -> IDLE on the handshake of the RLAST beat. s_arready=1 only in IDLE and is registered. It rises the cycle after the RLAST handshake. Back-to-back bursts therefore have 1 idle cycle.
- AR capture: latch addr, len, size, burst, id. Beat count = arlen+1 (1..256).
- Error check at capture, applied to the whole burst:
  - DECERR: start address outside [BASE_ADDR, BASE_ADDR+SPAN_BYTES).
  - SLVERR: arsize > log2(DATA_W/8), or WRAP with arlen not in {1,3,7,15}, or burst encoding 3, or an unaligned address (see Optional Feature).
  - On error: no mem_req is issued. arlen+1 beats are still returned with s_rdata=0, the error RRESP and the correct RLAST.
- Address generation, per issued beat, with step = 1<<size:
  - FIXED: constant.
  - INCR: addr += step, width ADDR_W, wraps modulo 2^ADDR_W. 4KB crossing is not checked.
  - WRAP: boundary = (len+1)*step. addr = (addr & ~(boundary-1)) | ((addr+step) & (boundary-1)).
  - mem_addr = addr with the low log2(DATA_W/8) bits cleared.
- Flow control: mem_req is issued only if (buffer_count + inflight - pop_this_cycle) < 2, where inflight is 0 or 1. This gives 1 beat/cycle when rready is held high and never overflows the buffer.
- Data lands in the buffer the cycle after mem_req. s_rvalid = buffer non-empty. R outputs are stable while rvalid=1 and rready=0.
- Simultaneous push and pop with the buffer full is legal; count is unchanged.
- Latency: AR handshake at cycle 0 -> mem_req at cycle 1 -> first rvalid at cycle 3 (error burst: first rvalid at cycle 2).
- RLAST is set on beat index == len. RID is constant for the burst. Narrow transfers return the full DATA_W word; the initiator selects lanes.

Optional Feature:
Macro AXI_RD_UNALIGNED_EN.
- Defined: an unaligned s_araddr is accepted. The first beat uses the unaligned address; later INCR beats align down to size then step (AXI rule). WRAP with an unaligned start is still SLVERR.
- Not defined: any araddr not aligned to arsize gives SLVERR for the whole burst.

Decomposition:
- Shared package (axi_pkg) gains:
  - burst-address function axiNextAddr(addr, size, len, burst)
  - axiWrapLenLegal(len)
  - constant AXI_BURST_RSVD = 2'd3
- It reuses AxiSize_t, AxiBurst_t, AxiResp_t, axiSize2bytes and axiAccepted.
- One sub-module: axi_rd_skid_buf. It is the 2-entry FIFO with valid/ready out and push-in, carrying {data, resp, last, id}.

Test Plan:
1. INCR, addr 0x100, len 3, size SIZE_4, rready=1 -> mem_addr 0x100/104/108/10C on consecutive cycles; 4 R beats back-to-back, RLAST on beat 3, RRESP OKAY, RID=ARID.
2. WRAP, addr 0x0C, len 3, size SIZE_4 -> mem_addr 0x0C, 0x00, 0x04, 0x08.
3. INCR, len 7, rready toggled 1/0 every cycle -> 8 beats in order, no loss or duplication, R stable while stalled, in-flight plus buffered never exceeds 2.
4. araddr = BASE_ADDR+SPAN_BYTES, len 2 -> no mem_req; 3 beats with DECERR and data 0, RLAST on the third.
5. araddr 0x102, size SIZE_4 -> SLVERR burst without the macro. With the macro: OKAY, mem_addr 0x100/104.
6. rst asserted after beat 1 of a len-3 burst -> rvalid=0 immediately; after release, arready=1 and a new len-0 FIXED burst returns exactly one beat with RLAST=1.
